dram_readback_checker: RTL and testbench
========================================

# dram_readback_checker

Read-side counterpart to the 16×8 distributed-RAM write sequence. It sweeps every address of the RAM, compares the asynchronous read data against the arithmetic fill pattern (entry i = BASE + STEP·i), and reports mismatch count, first failing address and pass/fail. It sits beside the DRAM instance, owning the address port while the write side is idle (we=0).

## Interface
- ADDR_W, 4, RAM address width; depth = 2^ADDR_W
- DATA_W, 8, RAM data width
- BASE, 1, expected value at address 0
- STEP, 2, expected increment per address

- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock, synchronous and active-high
- start  in  1  request a sweep; sampled only in IDLE
- a  out  ADDR_W  RAM read address (registered)
- spo  in  DATA_W  RAM asynchronous read data for address `a`
- busy  out  1  high during SCAN
- done  out  1  single-cycle pulse at sweep end
- pass  out  1  1 when last completed sweep had zero mismatches
- err_cnt  out  ADDR_W+1  mismatches in last sweep (0..2^ADDR_W)
- first_err_addr  out  ADDR_W  lowest mismatching address; 0 if none

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE: busy=0. On start=1: a←0, err_cnt←0, first_err_addr←0, pass←0, internal err_seen←0, go SCAN.
- SCAN: every cycle compare spo to exp(a) = (BASE + STEP·a) mod 2^DATA_W.
  - Compute in DATA_W+ADDR_W bits, truncate to DATA_W.
  - On mismatch: err_cnt←err_cnt+1; if err_seen=0 then first_err_addr←a, err_seen←1.
  - If a = 2^ADDR_W−1: go DONE, a held. Else a←a+1.
  - start ignored.
- DONE: done=1 for this cycle; pass←(err_cnt=0); go IDLE. start ignored in DONE.
- Results (pass, err_cnt, first_err_addr) hold until the next accepted start.
- err_cnt cannot overflow: width ADDR_W+1 holds 2^ADDR_W.
- Block never writes RAM; the write side keeps we=0 while busy=1. That is a system rule, not checked here.

## Timing
- Reset values: a=0, busy=0, done=0, pass=0, err_cnt=0, first_err_addr=0, state=IDLE.
- Cycle 0: start sampled high in IDLE. Cycles 1..2^ADDR_W: SCAN, busy=1, a = cycle−1.
- Cycle 2^ADDR_W+1: DONE, done=1, busy=0. pass becomes valid the following cycle.
- Default geometry: done exactly 17 cycles after the start-sampling edge.
- spo must settle within the cycle `a` is presented (async read). The compare uses the same-cycle spo.
- Start high continuously: a new sweep begins the cycle after DONE (IDLE sees start). Back-to-back period is 18 cycles.
- rst mid-sweep: next edge returns to IDLE with all outputs at reset values. A done pulse is not generated.
- rst and start in the same cycle: rst wins.

## Test plan
- RAM filled 1,3,5,…,31 (we=1 for 16 writes), then start pulse -> busy high 16 cycles, done at +17, pass=1, err_cnt=0, first_err_addr=0.
- Same fill, but address 5 overwritten with 0x00 -> err_cnt=1, first_err_addr=5, pass=0.
- RAM all zero -> err_cnt=16 (0x10, no wrap), first_err_addr=0, pass=0.
- Parameters BASE=0xF1, STEP=0x10 with a matching fill -> pass=1. This checks mod-256 wrap of exp at address 1 onward.
- start pulsed again at cycles 3 and 10 of a sweep -> ignored; single done at +17; a sequence 0..15 uninterrupted.
- rst asserted at SCAN cycle 8 -> next cycle all outputs at reset values, no done pulse. A subsequent start gives a full correct sweep.

Source files
------------

// File: rtl/dram_readback_checker.sv
// Sweeps a distributed RAM and checks every word against the BASE + STEP*i fill pattern,
// reporting the mismatch count, the lowest failing address and an overall pass flag.
module dram_readback_checker #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int BASE   = 1,
  parameter int STEP   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] spo,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int EXP_W = DATA_W + ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_a;
  logic [ADDR_W:0]     r_err_cnt;
  logic [ADDR_W-1:0]   r_first_err_addr;
  logic                r_err_seen;
  logic                r_pass;
  logic                w_busy;
  logic                w_done;
  logic [DATA_W-1:0]   w_exp;
  logic                w_mismatch;

  // Expected word is formed wide enough to hold BASE + STEP*a exactly, then wrapped.
  assign w_exp      = DATA_W'(EXP_W'(BASE) + EXP_W'(STEP) * EXP_W'(r_a));
  assign w_mismatch = (spo != w_exp);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: if (start) w_state_next = SCAN;
      SCAN: begin
        w_busy = 1'b1;
        if (r_a == LAST_ADDR) w_state_next = DONE;
      end
      DONE: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a              <= '0;
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
      r_err_seen       <= 1'b0;
      r_pass           <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a              <= '0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_err_seen       <= 1'b0;
            r_pass           <= 1'b0;
          end
        end
        SCAN: begin
          if (w_mismatch) begin
            r_err_cnt <= r_err_cnt + (ADDR_W+1)'(1);
            if (!r_err_seen) begin
              r_first_err_addr <= r_a;
              r_err_seen       <= 1'b1;
            end
          end
          // The last address is held so the RAM port stays stable through DONE.
          if (r_a != LAST_ADDR) r_a <= r_a + ADDR_W'(1);
        end
        DONE:    r_pass <= (r_err_cnt == '0);
        default: ;
      endcase
    end
  end

  assign a              = r_a;
  assign busy           = w_busy;
  assign done           = w_done;
  assign pass           = r_pass;
  assign err_cnt        = r_err_cnt;
  assign first_err_addr = r_first_err_addr;

endmodule

// File: tb/tb_dram_readback_checker.sv
// Directed bench: a small 16x8 RAM model feeds the checker; sweeps use hand-computed fills.
module tb_dram_readback_checker;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [7:0] spo;
  logic       busy, done, pass;
  logic [4:0] err_cnt;
  logic [3:0] first_err_addr;

  logic [3:0] a2;
  logic [7:0] spo2;
  logic       busy2, done2, pass2;
  logic [4:0] err_cnt2;
  logic [3:0] first_err_addr2;

  logic [7:0] mem  [16];
  logic [7:0] mem2 [16];
  logic       we;
  logic [3:0] wa;
  logic [7:0] wd;

  int checks   = 0;
  int failures = 0;

  dram_readback_checker dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .spo(spo),
    .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr)
  );

  dram_readback_checker #(.ADDR_W(4), .DATA_W(8), .BASE(8'hF1), .STEP(8'h10)) dut2 (
    .clk(clk), .rst(rst), .start(start), .a(a2), .spo(spo2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err_cnt2), .first_err_addr(first_err_addr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (we) mem[wa] <= wd;
  assign spo  = mem[a];
  assign spo2 = mem2[a2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [3:0] addr, input logic [7:0] data);
    we = 1'b1; wa = addr; wd = data;
    step();
    we = 1'b0;
  endtask

  // Odd-number fill 1,3,...,31 matching BASE=1, STEP=2.
  task automatic fill_good();
    logic [7:0] v;
    v = 8'd1;
    for (int i = 0; i < 16; i++) begin
      write_word(4'(i), v);
      v = v + 8'd2;
    end
  endtask

  // Called at #1 after an edge with the DUT in IDLE. Cycle numbering: the start-sampling
  // edge opens cycle 1; cycles 1..16 are SCAN, cycle 17 is DONE, cycle 18 is IDLE again.
  task automatic sweep(input string name, input bit glitch, input bit hold,
                       input logic exp_pass, input logic [4:0] exp_err, input logic [3:0] exp_first);
    int dones;
    dones = 0;
    start = 1'b1;
    step();
    if (!hold) start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      chk({name, " busy"}, 32'(busy), 32'd1);
      chk({name, " addr"}, 32'(a), 32'(c - 1));
      if (done) dones++;
      if (!hold) start = glitch && (c == 3 || c == 10);
      step();
    end
    start = hold;
    chk({name, " done@17"}, 32'(done), 32'd1);
    chk({name, " busy@17"}, 32'(busy), 32'd0);
    chk({name, " early_done"}, 32'(dones), 32'd0);
    step();
    chk({name, " done@18"}, 32'(done), 32'd0);
    chk({name, " pass"}, 32'(pass), 32'(exp_pass));
    chk({name, " err_cnt"}, 32'(err_cnt), 32'(exp_err));
    chk({name, " first_err"}, 32'(first_err_addr), 32'(exp_first));
    $display("sweep %s: pass=%0d err_cnt=%0d first_err_addr=%0d", name, pass, err_cnt, first_err_addr);
    if (hold) begin
      step();
      chk({name, " b2b busy@19"}, 32'(busy), 32'd1);
      chk({name, " b2b addr@19"}, 32'(a), 32'd0);
    end
  endtask

  initial begin
    int dones;
    rst = 1'b1; start = 1'b0; we = 1'b0; wa = '0; wd = '0;
    for (int i = 0; i < 16; i++) begin
      mem[i]  = 8'h00;
      mem2[i] = 8'(241 + 16 * i);
    end
    step();
    step();
    chk("rst a", 32'(a), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst pass", 32'(pass), 32'd0);
    chk("rst err_cnt", 32'(err_cnt), 32'd0);
    chk("rst first_err", 32'(first_err_addr), 32'd0);
    rst = 1'b0;
    step();

    fill_good();
    sweep("good", 1'b0, 1'b0, 1'b1, 5'd0, 4'd0);
    chk("wrap pass", 32'(pass2), 32'd1);
    chk("wrap err_cnt", 32'(err_cnt2), 32'd0);
    chk("wrap mem2[1]", 32'(mem2[1]), 32'h01);

    write_word(4'd5, 8'h00);
    sweep("addr5_bad", 1'b0, 1'b0, 1'b0, 5'd1, 4'd5);

    for (int i = 0; i < 16; i++) write_word(4'(i), 8'h00);
    sweep("all_zero", 1'b0, 1'b0, 1'b0, 5'd16, 4'd0);

    fill_good();
    sweep("start_glitch", 1'b1, 1'b0, 1'b1, 5'd0, 4'd0);

    // Continuous start: the second sweep opens at cycle 19, then is aborted by reset at cycle 8.
    sweep("back_to_back", 1'b0, 1'b1, 1'b1, 5'd0, 4'd0);
    start = 1'b0;
    for (int c = 2; c <= 8; c++) step();
    chk("abort addr@8", 32'(a), 32'd7);
    rst = 1'b1;
    step();
    chk("abort a", 32'(a), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort pass", 32'(pass), 32'd0);
    chk("abort err_cnt", 32'(err_cnt), 32'd0);
    chk("abort first_err", 32'(first_err_addr), 32'd0);
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (done || busy) dones++;
    end
    chk("abort no_done", 32'(dones), 32'd0);

    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    chk("rst_wins busy", 32'(busy), 32'd0);
    step();
    chk("rst_wins idle", 32'(busy), 32'd0);

    sweep("after_abort", 1'b0, 1'b0, 1'b1, 5'd0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
